// File: rtl/pipe_control_unit_if.sv
// Bundle of the in-order pipeline control signals between the ID stage
// driver and the pipe_control_unit.
interface pipe_control_unit_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
);
  logic [OPW-1:0]  OPcode;
  logic            ID_VALID;
  logic            STALL;
  logic            FLUSH;
  logic [8:0]      CONTROL_PIPE;
  logic [1:0]      ALU_OP;
  logic [8:0]      EX_CTRL;
  logic [1:0]      EX_ALU_OP;
  logic [8:0]      MEM_CTRL;
  logic [8:0]      WB_CTRL;
  logic            EX_VALID;
  logic            MEM_VALID;
  logic            WB_VALID;
  logic            ILLEGAL;
  logic            HALTED;
  logic [CNTW-1:0] RETIRED;

  modport master (
    output OPcode, ID_VALID, STALL, FLUSH,
    input  CONTROL_PIPE, ALU_OP, EX_CTRL, EX_ALU_OP, MEM_CTRL, WB_CTRL,
           EX_VALID, MEM_VALID, WB_VALID, ILLEGAL, HALTED, RETIRED
  );

  modport slave (
    input  OPcode, ID_VALID, STALL, FLUSH,
    output CONTROL_PIPE, ALU_OP, EX_CTRL, EX_ALU_OP, MEM_CTRL, WB_CTRL,
           EX_VALID, MEM_VALID, WB_VALID, ILLEGAL, HALTED, RETIRED
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Opcode decode plus EX/MEM/WB control pipeline with stall, flush,
// illegal-opcode pulse, sticky halt and a saturating retire counter.
module pipe_control_unit #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input logic                CLK,
  input logic                RST,
  pipe_control_unit_if.slave bus
);

  // Control word layout: [8]REG_WRITE [7]MEM_TO_REG [6]MEM_WRITE [5]MEM_READ
  // [4]BRANCH [3]JUMP [2]ALU_SRC [1]REG_DST [0]HALT
  localparam logic [8:0] C_RTYPE = 9'b100000010;
  localparam logic [8:0] C_ADDI  = 9'b100000100;
  localparam logic [8:0] C_LW    = 9'b110100100;
  localparam logic [8:0] C_SW    = 9'b001000100;
  localparam logic [8:0] C_BR    = 9'b000010000;
  localparam logic [8:0] C_JMP   = 9'b000001000;
  localparam logic [8:0] C_HLT   = 9'b000000001;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
  localparam logic [OPW-1:0] OP_LW   = OPW'(5);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(7);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(8);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(9);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(10);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(11);
  localparam logic [OPW-1:0] OP_HLT  = OPW'(12);

  logic [8:0] dec_ctrl;
  logic [1:0] dec_alu;
  logic       dec_legal;
  logic       issue_ok;
  logic       accept;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted opcodes would infer latches.
  always_comb begin
    dec_ctrl  = '0;
    dec_alu   = 2'b00;
    dec_legal = 1'b1;
    unique case (bus.OPcode)
      OP_ADD:  dec_ctrl = C_RTYPE;
      OP_SUB:  begin dec_ctrl = C_RTYPE; dec_alu = 2'b01; end
      OP_AND:  begin dec_ctrl = C_RTYPE; dec_alu = 2'b10; end
      OP_OR:   begin dec_ctrl = C_RTYPE; dec_alu = 2'b11; end
      OP_ADDI: dec_ctrl = C_ADDI;
      OP_LW:   dec_ctrl = C_LW;
      OP_SW:   dec_ctrl = C_SW;
      OP_BEQ:  begin dec_ctrl = C_BR; dec_alu = 2'b01; end
      OP_BNE:  begin dec_ctrl = C_BR; dec_alu = 2'b01; end
      OP_JMP:  dec_ctrl = C_JMP;
      OP_SLT:  begin dec_ctrl = C_RTYPE; dec_alu = 2'b01; end
      OP_NOP:  dec_ctrl = '0;
      OP_HLT:  dec_ctrl = C_HLT;
      default: dec_legal = 1'b0;
    endcase
  end

  assign bus.CONTROL_PIPE = dec_ctrl;
  assign bus.ALU_OP       = dec_alu;

  // An instruction may leave ID only when nothing is holding or killing it.
  assign issue_ok = bus.ID_VALID & ~bus.STALL & ~bus.FLUSH & ~bus.HALTED;
  assign accept   = issue_ok & dec_legal;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.EX_CTRL   <= '0;
      bus.EX_ALU_OP <= 2'b00;
      bus.EX_VALID  <= 1'b0;
      bus.MEM_CTRL  <= '0;
      bus.MEM_VALID <= 1'b0;
      bus.WB_CTRL   <= '0;
      bus.WB_VALID  <= 1'b0;
      bus.ILLEGAL   <= 1'b0;
      bus.HALTED    <= 1'b0;
      bus.RETIRED   <= '0;
    end else begin
      if (accept) begin
        bus.EX_CTRL   <= dec_ctrl;
        bus.EX_ALU_OP <= dec_alu;
        bus.EX_VALID  <= 1'b1;
      end else begin
        bus.EX_CTRL   <= '0;
        bus.EX_ALU_OP <= 2'b00;
        bus.EX_VALID  <= 1'b0;
      end

      // A taken branch/jump kills whatever was in EX; flush wins over stall.
      if (bus.FLUSH) begin
        bus.MEM_CTRL  <= '0;
        bus.MEM_VALID <= 1'b0;
      end else begin
        bus.MEM_CTRL  <= bus.EX_CTRL;
        bus.MEM_VALID <= bus.EX_VALID;
      end

      bus.WB_CTRL  <= bus.MEM_CTRL;
      bus.WB_VALID <= bus.MEM_VALID;

      bus.ILLEGAL <= issue_ok & ~dec_legal;

      if (bus.WB_VALID && bus.WB_CTRL[0])
        bus.HALTED <= 1'b1;

      if (bus.WB_VALID && (bus.RETIRED != {CNTW{1'b1}}))
        bus.RETIRED <= bus.RETIRED + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode table sweep, then hand-built
// pipeline sequences for latency, stall, flush, illegal, halt and saturation.
module tb_pipe_control_unit;

  localparam int OPW  = 4;
  localparam int CNTW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_control_unit_if #(.OPW(OPW), .CNTW(CNTW)) bus ();

  pipe_control_unit #(.OPW(OPW), .CNTW(CNTW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [8:0] ctrl;
    logic [1:0] alu;
  } dec_vec_t;

  dec_vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.OPcode   = '0;
    bus.ID_VALID = 1'b0;
    bus.STALL    = 1'b0;
    bus.FLUSH    = 1'b0;
  endtask

  // Asynchronous reset away from any clock edge, then release between edges.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_ex_valid", 32'(bus.EX_VALID), 0);
    check("rst_wb_valid", 32'(bus.WB_VALID), 0);
    check("rst_halted",   32'(bus.HALTED), 0);
    check("rst_retired",  32'(bus.RETIRED), 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  9'b100000010, 2'b00};
    vecs[1]  = '{4'd1,  9'b100000010, 2'b01};
    vecs[2]  = '{4'd2,  9'b100000010, 2'b10};
    vecs[3]  = '{4'd3,  9'b100000010, 2'b11};
    vecs[4]  = '{4'd4,  9'b100000100, 2'b00};
    vecs[5]  = '{4'd5,  9'b110100100, 2'b00};
    vecs[6]  = '{4'd6,  9'b001000100, 2'b00};
    vecs[7]  = '{4'd7,  9'b000010000, 2'b01};
    vecs[8]  = '{4'd8,  9'b000010000, 2'b01};
    vecs[9]  = '{4'd9,  9'b000001000, 2'b00};
    vecs[10] = '{4'd10, 9'b100000010, 2'b01};
    vecs[11] = '{4'd11, 9'b000000000, 2'b00};
    vecs[12] = '{4'd12, 9'b000000001, 2'b00};
    vecs[13] = '{4'd13, 9'b000000000, 2'b00};
    vecs[14] = '{4'd14, 9'b000000000, 2'b00};
    vecs[15] = '{4'd15, 9'b000000000, 2'b00};

    idle_inputs();
    #2;
    check("por_ex_ctrl", 32'(bus.EX_CTRL), 0);
    check("por_illegal", 32'(bus.ILLEGAL), 0);
    check("por_retired", 32'(bus.RETIRED), 0);
    @(negedge clk);
    rst = 1'b0;

    // Decode sweep with ID_VALID low: nothing may enter EX.
    for (int i = 0; i < 16; i++) begin
      bus.OPcode = vecs[i].op;
      #1;
      check($sformatf("dec_ctrl_%0d", i), 32'(bus.CONTROL_PIPE), 32'(vecs[i].ctrl));
      check($sformatf("dec_alu_%0d", i),  32'(bus.ALU_OP), 32'(vecs[i].alu));
      step();
      check($sformatf("sweep_ex_valid_%0d", i), 32'(bus.EX_VALID), 0);
      check($sformatf("sweep_illegal_%0d", i),  32'(bus.ILLEGAL), 0);
    end

    // LW latency through EX, MEM, WB and retirement.
    do_reset();
    bus.OPcode = 4'd5; bus.ID_VALID = 1'b1;
    step();
    bus.ID_VALID = 1'b0;
    check("lw_ex_ctrl",  32'(bus.EX_CTRL), 32'(9'b110100100));
    check("lw_ex_valid", 32'(bus.EX_VALID), 1);
    step();
    check("lw_mem_ctrl",  32'(bus.MEM_CTRL), 32'(9'b110100100));
    check("lw_ex_bubble", 32'(bus.EX_VALID), 0);
    step();
    check("lw_wb_ctrl",  32'(bus.WB_CTRL), 32'(9'b110100100));
    check("lw_wb_valid", 32'(bus.WB_VALID), 1);
    check("lw_ret_pre",  32'(bus.RETIRED), 0);
    step();
    check("lw_retired", 32'(bus.RETIRED), 1);

    // ADD, two stall cycles, SUB.
    do_reset();
    bus.OPcode = 4'd0; bus.ID_VALID = 1'b1;
    step();
    check("stall_ex_add", 32'(bus.EX_CTRL), 32'(9'b100000010));
    check("stall_ex_add_v", 32'(bus.EX_VALID), 1);
    bus.OPcode = 4'd1; bus.STALL = 1'b1;
    step();
    check("stall_ex_b1", 32'(bus.EX_VALID), 0);
    check("stall_mem_add", 32'(bus.MEM_CTRL), 32'(9'b100000010));
    check("stall_ill1", 32'(bus.ILLEGAL), 0);
    step();
    check("stall_ex_b2", 32'(bus.EX_VALID), 0);
    check("stall_wb_add", 32'(bus.WB_VALID), 1);
    bus.STALL = 1'b0;
    step();
    bus.ID_VALID = 1'b0;
    check("stall_ex_sub", 32'(bus.EX_CTRL), 32'(9'b100000010));
    check("stall_ex_sub_alu", 32'(bus.EX_ALU_OP), 1);
    check("stall_ex_sub_v", 32'(bus.EX_VALID), 1);
    check("stall_ill2", 32'(bus.ILLEGAL), 0);

    // FLUSH together with STALL: BEQ in EX, ADD in MEM, ADD in ID.
    do_reset();
    bus.OPcode = 4'd0; bus.ID_VALID = 1'b1;
    step();
    bus.OPcode = 4'd7;
    step();
    check("fl_ex_beq", 32'(bus.EX_CTRL), 32'(9'b000010000));
    bus.OPcode = 4'd0; bus.STALL = 1'b1; bus.FLUSH = 1'b1;
    step();
    idle_inputs();
    check("fl_ex_bubble",  32'(bus.EX_VALID), 0);
    check("fl_mem_bubble", 32'(bus.MEM_VALID), 0);
    check("fl_mem_ctrl",   32'(bus.MEM_CTRL), 0);
    check("fl_wb_valid",   32'(bus.WB_VALID), 1);
    check("fl_wb_ctrl",    32'(bus.WB_CTRL), 32'(9'b100000010));

    // Illegal opcode 14: one-cycle pulse, becomes a bubble, not retired.
    do_reset();
    bus.OPcode = 4'd14; bus.ID_VALID = 1'b1;
    step();
    bus.ID_VALID = 1'b0;
    check("ill_pulse", 32'(bus.ILLEGAL), 1);
    check("ill_ex_valid", 32'(bus.EX_VALID), 0);
    step();
    check("ill_pulse_end", 32'(bus.ILLEGAL), 0);
    step(); step(); step();
    check("ill_retired", 32'(bus.RETIRED), 0);
    // Illegal opcode under stall is not accepted, so no pulse.
    bus.ID_VALID = 1'b1; bus.STALL = 1'b1;
    step();
    idle_inputs();
    check("ill_stalled", 32'(bus.ILLEGAL), 0);

    // HLT followed by a stream of ADDs.
    do_reset();
    bus.OPcode = 4'd12; bus.ID_VALID = 1'b1;
    step();
    check("hlt_ex", 32'(bus.EX_CTRL), 32'(9'b000000001));
    bus.OPcode = 4'd0;
    step();
    step();
    check("hlt_in_wb", 32'(bus.WB_CTRL), 32'(9'b000000001));
    check("hlt_not_yet", 32'(bus.HALTED), 0);
    step();
    check("hlt_set", 32'(bus.HALTED), 1);
    check("hlt_ret1", 32'(bus.RETIRED), 1);
    step();
    check("hlt_block_ex", 32'(bus.EX_VALID), 0);
    for (int i = 0; i < 5; i++) step();
    check("hlt_drained_ret", 32'(bus.RETIRED), 4);
    check("hlt_ex_still_0", 32'(bus.EX_VALID), 0);
    check("hlt_wb_empty", 32'(bus.WB_VALID), 0);
    check("hlt_sticky", 32'(bus.HALTED), 1);
    do_reset();
    check("hlt_cleared", 32'(bus.HALTED), 0);

    // Saturation of the 3-bit retire counter with a NOP stream.
    bus.OPcode = 4'd11; bus.ID_VALID = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("sat_ret6", 32'(bus.RETIRED), 6);
    step();
    check("sat_ret7", 32'(bus.RETIRED), 7);
    step(); step();
    check("sat_hold", 32'(bus.RETIRED), 7);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
